idma_desc64_apb_submit_queue: RTL and testbench
===============================================

Name: idma_desc64_apb_submit_queue

Overview:
- Multi-channel APB submission front for the desc64 frontend: software writes descriptor addresses to per-channel doorbell registers.
- Each address is buffered in a per-channel FIFO and presented to the descriptor fetchers as ready/valid streams.
- When a FIFO is full, the block either inserts APB wait states (backpressure) or returns an error, selectable by parameter.
- Also exposes per-channel fill level and a software flush.

Parameters:
- NumChannels, 2, number of independent submission channels (1..16).
- FifoDepth, 4, entries per channel FIFO (power of two, >=2).
- AddrWidth, 64, descriptor address width; equals APB data width.
- StallOnFull, 1, 1: hold pready low while full; 0: complete immediately with pslverr and drop the write.
- apb_req_t, logic, APB request struct (paddr, pwrite, pwdata, pstrb, psel, penable, pprot).
- apb_rsp_t, logic, APB response struct (prdata, pready, pslverr).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- apb_req_i  in  apb_req_t  APB request.
- apb_rsp_o  out  apb_rsp_t  APB response.
- desc_addr_o  out  NumChannels x AddrWidth  head address per channel.
- desc_valid_o  out  NumChannels  head valid per channel.
- desc_ready_i  in  NumChannels  consumer accepts the head.

Behaviour:
- Reset: all FIFOs empty, desc_valid_o=0, desc_addr_o=0, prdata=0, pready=0, pslverr=0, FSM=IDLE. Reset mid-transfer drops the transfer and clears the queues.
- Address map:
  - Channel index c = paddr[4 +: clog2(NumChannels)]; register = paddr[3:0].
  - 0x0 DESC_ADDR: W enqueues pwdata; R returns the last enqueued address.
  - 0x8 STATUS: R bit0 empty, bit1 full, bits[15:8] fill count. W with bit0=1 flushes the channel.
  - Channel >= NumChannels or any other offset: pslverr=1, no side effect, prdata=0.
- FSM states:
  - IDLE: on psel & ~penable, go to ACCESS.
  - ACCESS: psel & penable. Respond with pready=1 in the same cycle (zero wait), except a DESC_ADDR write to a full FIFO with StallOnFull=1, which goes to WAIT with pready=0.
  - WAIT: pready=0 until the FIFO has space, then enqueue and pready=1; return to IDLE.
  - psel dropping while in WAIT: abort to IDLE with no enqueue (protocol violation tolerated).
- Enqueue occurs exactly in the cycle pready=1 for a valid DESC_ADDR write. pstrb must be all ones, otherwise pslverr=1 with no enqueue.
- Full and StallOnFull=0: pready=1, pslverr=1, write dropped.
- Pop: desc_valid_o & desc_ready_i. Head is registered; desc_addr_o is stable while valid & ~ready.
- Push and pop on the same cycle in the same channel: count unchanged; allowed even when full, since the pop frees space combinationally for the WAIT-state check. A push into an empty FIFO becomes visible on desc_valid_o the next cycle (1-cycle latency).
- Flush takes precedence over a simultaneous pop and clears the count. A flush while another channel is in WAIT is independent.
- Only one APB transfer is outstanding at a time; the other channels keep draining during WAIT.
- Read-pointer and write-pointer wrap modulo FifoDepth; count width clog2(FifoDepth)+1.

Decomposition:
- Package idma_desc64_submit_pkg: register offsets (DESC_ADDR_OFFSET=0x0, STATUS_OFFSET=0x8, CHAN_STRIDE=0x10), STATUS bit positions, FSM state enum.
- Sub-module idma_desc64_addr_fifo (AddrWidth, FifoDepth; push, pop, flush, full, empty, count, head), instantiated NumChannels times.

Test Plan:
- Write 0x1000 to ch0 DESC_ADDR, desc_ready_i=1 -> pready=1 in the ACCESS cycle; desc_valid_o[0]=1 with addr 0x1000 one cycle later, then cleared.
- desc_ready_i=0, five writes to ch1 (FifoDepth=4), StallOnFull=1 -> first four complete with zero wait; fifth holds pready=0 until desc_ready_i[1]=1 for one cycle, then completes; STATUS reads count=4, full=1.
- Same as above with StallOnFull=0 -> fifth write returns pready=1, pslverr=1; queue still holds the original four addresses in order.
- Two entries queued in ch0, write STATUS=0x1 on the same cycle as desc_ready_i[0]=1 -> count=0, desc_valid_o[0]=0 next cycle, no further pops.
- Access to channel 3 with NumChannels=2, and a DESC_ADDR write with pstrb=0x0F -> pslverr=1, prdata=0, no enqueue anywhere.
- Assert rst_i during WAIT -> pready=0, all desc_valid_o=0 immediately (asynchronous); after release, STATUS reads empty on all channels.

Source files
------------

// File: rtl/idma_desc64_submit_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// idma_desc64_submit_pkg : register map, status layout, FSM states and APB types
// rev 1.0
// ----------------------------------------------------------------------------
package idma_desc64_submit_pkg;

  localparam logic [3:0]  DESC_ADDR_OFFSET = 4'h0;
  localparam logic [3:0]  STATUS_OFFSET    = 4'h8;
  localparam int unsigned CHAN_STRIDE      = 32'h10;
  localparam int unsigned CHAN_SHIFT       = $clog2(CHAN_STRIDE);

  localparam int unsigned STATUS_EMPTY_BIT = 0;
  localparam int unsigned STATUS_FULL_BIT  = 1;
  localparam int unsigned STATUS_FLUSH_BIT = 0;
  localparam int unsigned STATUS_COUNT_LSB = 8;
  localparam int unsigned STATUS_COUNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2
  } submit_state_e;

  typedef struct packed {
    logic [31:0] paddr;
    logic        pwrite;
    logic [63:0] pwdata;
    logic [7:0]  pstrb;
    logic        psel;
    logic        penable;
    logic [2:0]  pprot;
  } apb_req_64_t;

  typedef struct packed {
    logic [63:0] prdata;
    logic        pready;
    logic        pslverr;
  } apb_rsp_64_t;

endpackage
`default_nettype wire

// File: rtl/idma_desc64_addr_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// idma_desc64_addr_fifo : per-channel descriptor address FIFO with flush
// rev 1.0
// ----------------------------------------------------------------------------
module idma_desc64_addr_fifo #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_push,
  input  logic [ADDR_WIDTH-1:0]       i_data,
  input  logic                        i_pop,
  input  logic                        i_flush,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [$clog2(FIFO_DEPTH):0] o_count,
  output logic [ADDR_WIDTH-1:0]       o_head
);

  localparam int unsigned c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned c_CNT_W = c_PTR_W + 1;

  logic [ADDR_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_CNT_W-1:0]    r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_full  = (r_count == c_CNT_W'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // a pop in the same cycle frees the slot the push lands in
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
  assign w_do_push = i_push & ~i_flush & (~o_full | w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/idma_desc64_apb_submit_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// idma_desc64_apb_submit_queue : APB doorbell front feeding per-channel FIFOs
// rev 1.0
// ----------------------------------------------------------------------------
module idma_desc64_apb_submit_queue
  import idma_desc64_submit_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS  = 2,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned ADDR_WIDTH    = 64,
  parameter bit          STALL_ON_FULL = 1'b1,
  parameter type         apb_req_t     = apb_req_64_t,
  parameter type         apb_rsp_t     = apb_rsp_64_t
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  apb_req_t                               apb_req_i,
  output apb_rsp_t                               apb_rsp_o,
  output logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] desc_addr_o,
  output logic [NUM_CHANNELS-1:0]                desc_valid_o,
  input  logic [NUM_CHANNELS-1:0]                desc_ready_i
);

  localparam int unsigned c_CHAN_IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned c_CNT_W      = $clog2(FIFO_DEPTH) + 1;

  submit_state_e         r_state;
  submit_state_e         w_state_next;
  apb_rsp_t              w_rsp;

  logic [31:0]             w_chan_full;
  logic [c_CHAN_IDX_W-1:0] w_chan;
  logic [3:0]              w_reg;
  logic                    w_chan_ok;
  logic                    w_is_desc;
  logic                    w_is_status;
  logic                    w_reg_ok;
  logic                    w_strb_ok;
  logic                    w_xfer;
  logic                    w_wr_ok;
  logic                    w_space;
  logic                    w_stall;
  logic                    w_push_en;
  logic                    w_flush_en;
  logic [ADDR_WIDTH-1:0]   w_status;
  logic                    w_unused_pprot;

  logic [NUM_CHANNELS-1:0] w_full;
  logic [NUM_CHANNELS-1:0] w_empty;
  logic [NUM_CHANNELS-1:0] w_pop;
  logic [c_CNT_W-1:0]      w_count [NUM_CHANNELS];
  logic [ADDR_WIDTH-1:0]   w_last  [NUM_CHANNELS];

  // the full channel index is compared so out-of-range channels never alias
  assign w_chan_full = 32'(apb_req_i.paddr >> CHAN_SHIFT);
  assign w_chan      = w_chan_full[c_CHAN_IDX_W-1:0];
  assign w_chan_ok   = (w_chan_full < NUM_CHANNELS);
  assign w_reg       = apb_req_i.paddr[3:0];
  assign w_is_desc   = (w_reg == DESC_ADDR_OFFSET);
  assign w_is_status = (w_reg == STATUS_OFFSET);
  assign w_reg_ok    = w_chan_ok & (w_is_desc | w_is_status);
  assign w_strb_ok   = &apb_req_i.pstrb;
  assign w_xfer      = apb_req_i.psel & apb_req_i.penable;
  assign w_wr_ok     = w_reg_ok & w_is_desc & apb_req_i.pwrite & w_strb_ok;
  assign w_space     = ~w_full[w_chan] | w_pop[w_chan];
  assign w_stall     = w_wr_ok & ~w_space & STALL_ON_FULL;

  assign w_unused_pprot = ^apb_req_i.pprot;
  assign apb_rsp_o      = w_rsp;

  always_comb begin
    w_status = '0;
    w_status[STATUS_EMPTY_BIT] = w_empty[w_chan];
    w_status[STATUS_FULL_BIT]  = w_full[w_chan];
    w_status[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(w_count[w_chan]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (apb_req_i.psel && !apb_req_i.penable) begin
          w_state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_state_next = (w_xfer && w_stall) ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        // a master dropping psel mid-wait abandons the write
        if (!apb_req_i.psel || w_space) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rsp      = '0;
    w_push_en  = 1'b0;
    w_flush_en = 1'b0;
    case (r_state)
      ST_ACCESS: begin
        if (w_xfer && !w_stall) begin
          w_rsp.pready = 1'b1;
          if (!w_reg_ok) begin
            w_rsp.pslverr = 1'b1;
          end else if (w_is_desc) begin
            if (!apb_req_i.pwrite) begin
              w_rsp.prdata = w_last[w_chan];
            end else if (!w_strb_ok || !w_space) begin
              w_rsp.pslverr = 1'b1;
            end else begin
              w_push_en = 1'b1;
            end
          end else if (apb_req_i.pwrite) begin
            w_flush_en = apb_req_i.pwdata[STATUS_FLUSH_BIT];
          end else begin
            w_rsp.prdata = w_status;
          end
        end
      end
      ST_WAIT: begin
        if (w_xfer && w_space) begin
          w_rsp.pready = 1'b1;
          w_push_en    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  for (genvar g = 0; g < int'(NUM_CHANNELS); g++) begin : g_chan
    logic                  w_sel;
    logic [ADDR_WIDTH-1:0] r_last;

    assign w_sel           = w_chan_ok & (w_chan == c_CHAN_IDX_W'(g));
    assign w_pop[g]        = desc_valid_o[g] & desc_ready_i[g];
    assign desc_valid_o[g] = ~w_empty[g];
    assign w_last[g]       = r_last;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_last <= '0;
      end else if (w_push_en && w_sel) begin
        r_last <= apb_req_i.pwdata;
      end
    end

    idma_desc64_addr_fifo #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk_i),
      .rst     (rst_i),
      .i_push  (w_push_en & w_sel),
      .i_data  (apb_req_i.pwdata),
      .i_pop   (w_pop[g]),
      .i_flush (w_flush_en & w_sel),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g]),
      .o_count (w_count[g]),
      .o_head  (desc_addr_o[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_idma_desc64_apb_submit_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_idma_desc64_apb_submit_queue : scoreboard bench, stalling and dropping DUTs
// rev 1.0
// ----------------------------------------------------------------------------
module tb_idma_desc64_apb_submit_queue;
  import idma_desc64_submit_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  apb_req_64_t      req    [2];
  apb_rsp_64_t      rsp    [2];
  logic [1:0][63:0] daddr  [2];
  logic [1:0]       dvalid [2];
  logic [1:0]       dready [2];

  int total = 0;
  int bad   = 0;
  // index = dut*2 + channel
  logic [63:0] exp_q [4][$];

  always #5 clk = ~clk;

  idma_desc64_apb_submit_queue #(
    .NUM_CHANNELS(2), .FIFO_DEPTH(4), .ADDR_WIDTH(64), .STALL_ON_FULL(1'b1),
    .apb_req_t(apb_req_64_t), .apb_rsp_t(apb_rsp_64_t)
  ) u_dut_stall (
    .clk_i(clk), .rst_i(rst), .apb_req_i(req[0]), .apb_rsp_o(rsp[0]),
    .desc_addr_o(daddr[0]), .desc_valid_o(dvalid[0]), .desc_ready_i(dready[0])
  );

  idma_desc64_apb_submit_queue #(
    .NUM_CHANNELS(2), .FIFO_DEPTH(4), .ADDR_WIDTH(64), .STALL_ON_FULL(1'b0),
    .apb_req_t(apb_req_64_t), .apb_rsp_t(apb_rsp_64_t)
  ) u_dut_drop (
    .clk_i(clk), .rst_i(rst), .apb_req_i(req[1]), .apb_rsp_o(rsp[1]),
    .desc_addr_o(daddr[1]), .desc_valid_o(dvalid[1]), .desc_ready_i(dready[1])
  );

  task automatic apb_xfer(input int sel, input logic [31:0] addr, input logic wr,
                          input logic [63:0] wdata, input logic [7:0] strb,
                          output logic [63:0] rdata, output logic err, output int waits);
    bit done = 0;
    @(posedge clk); #1;
    req[sel].paddr   = addr;
    req[sel].pwrite  = wr;
    req[sel].pwdata  = wdata;
    req[sel].pstrb   = wr ? strb : 8'h00;
    req[sel].psel    = 1'b1;
    req[sel].penable = 1'b0;
    @(posedge clk); #1;
    req[sel].penable = 1'b1;
    waits = 0;
    rdata = '0;
    err   = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (rsp[sel].pready === 1'b1) begin
        rdata = rsp[sel].prdata;
        err   = rsp[sel].pslverr;
        done  = 1;
      end else begin
        waits++;
        if (waits > 50) begin
          total++; bad++;
          $display("FAIL apb_timeout: addr %h got no pready after %0d cycles, required pready=1", addr, waits);
          err  = 1'bx;
          done = 1;
        end
      end
    end
    @(posedge clk); #1;
    req[sel].psel    = 1'b0;
    req[sel].penable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req[0] = '0; req[1] = '0;
    dready[0] = '0; dready[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      total++;
      if ({rsp[s].pready, rsp[s].pslverr} !== 2'b00) begin
        bad++; $display("FAIL reset_rsp[%0d]: got %b required 00", s, {rsp[s].pready, rsp[s].pslverr});
      end
      total++;
      if (rsp[s].prdata !== 64'h0) begin
        bad++; $display("FAIL reset_prdata[%0d]: got %h required 0", s, rsp[s].prdata);
      end
      total++;
      if (dvalid[s] !== 2'b00) begin
        bad++; $display("FAIL reset_valid[%0d]: got %b required 00", s, dvalid[s]);
      end
      total++;
      if (daddr[s] !== '0) begin
        bad++; $display("FAIL reset_addr[%0d]: got %h required 0", s, daddr[s]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_push();
    logic [63:0] rd, e;
    logic err;
    int waits;
    dready[0] = 2'b01;
    exp_q[0].push_back(64'h1000);
    apb_xfer(0, 32'h0, 1'b1, 64'h1000, 8'hFF, rd, err, waits);
    total++;
    if (waits !== 0 || err !== 1'b0) begin
      bad++; $display("FAIL single_resp: got waits=%0d err=%b required waits=0 err=0", waits, err);
    end
    @(negedge clk);
    total++;
    if (exp_q[0].size() == 0) begin
      bad++; $display("FAIL single_pop: got pop with empty scoreboard, required none");
    end else begin
      e = exp_q[0].pop_front();
      if (dvalid[0][0] !== 1'b1 || daddr[0][0] !== e) begin
        bad++; $display("FAIL single_pop: got valid=%b addr=%h required valid=1 addr=%h", dvalid[0][0], daddr[0][0], e);
      end
    end
    @(negedge clk);
    total++;
    if (dvalid[0][0] !== 1'b0) begin
      bad++; $display("FAIL single_clear: got valid=%b required 0", dvalid[0][0]);
    end
    dready[0] = 2'b00;
  endtask

  task automatic test_stall_on_full();
    logic [63:0] rd, e, a;
    logic err;
    int waits;
    dready[0] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      a = 64'hA000 + 64'(i) * 64'h100;
      exp_q[1].push_back(a);
      apb_xfer(0, 32'h10, 1'b1, a, 8'hFF, rd, err, waits);
      total++;
      if (waits !== 0 || err !== 1'b0) begin
        bad++; $display("FAIL stall_fill%0d: got waits=%0d err=%b required waits=0 err=0", i, waits, err);
      end
    end
    exp_q[1].push_back(64'hA400);
    fork
      apb_xfer(0, 32'h10, 1'b1, 64'hA400, 8'hFF, rd, err, waits);
      begin
        repeat (6) @(posedge clk);
        #1 dready[0][1] = 1'b1;
        @(negedge clk);
        total++;
        if (exp_q[1].size() == 0) begin
          bad++; $display("FAIL stall_release_pop: got pop with empty scoreboard, required none");
        end else begin
          e = exp_q[1].pop_front();
          if (dvalid[0][1] !== 1'b1 || daddr[0][1] !== e) begin
            bad++; $display("FAIL stall_release_pop: got valid=%b addr=%h required valid=1 addr=%h", dvalid[0][1], daddr[0][1], e);
          end
        end
        @(posedge clk);
        #1 dready[0][1] = 1'b0;
      end
    join
    total++;
    if (waits !== 4 || err !== 1'b0) begin
      bad++; $display("FAIL stall_fifth: got waits=%0d err=%b required waits=4 err=0", waits, err);
    end
    apb_xfer(0, 32'h18, 1'b0, 64'h0, 8'h00, rd, err, waits);
    total++;
    if (err !== 1'b0 || rd[15:8] !== 8'd4 || rd[1:0] !== 2'b10) begin
      bad++; $display("FAIL stall_status: got err=%b status=%h required err=0 count=4 full=1 empty=0", err, rd);
    end
    apb_xfer(0, 32'h10, 1'b0, 64'h0, 8'h00, rd, err, waits);
    total++;
    if (err !== 1'b0 || rd !== 64'hA400) begin
      bad++; $display("FAIL stall_last_addr: got err=%b data=%h required err=0 data=a400", err, rd);
    end
    dready[0][1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (exp_q[1].size() == 0) begin
        bad++; $display("FAIL stall_drain%0d: got pop with empty scoreboard, required none", i);
      end else begin
        e = exp_q[1].pop_front();
        if (dvalid[0][1] !== 1'b1 || daddr[0][1] !== e) begin
          bad++; $display("FAIL stall_drain%0d: got valid=%b addr=%h required valid=1 addr=%h", i, dvalid[0][1], daddr[0][1], e);
        end
      end
    end
    @(posedge clk);
    #1 dready[0][1] = 1'b0;
    @(negedge clk);
    total++;
    if (dvalid[0][1] !== 1'b0) begin
      bad++; $display("FAIL stall_empty: got valid=%b required 0", dvalid[0][1]);
    end
  endtask

  task automatic test_drop_on_full();
    logic [63:0] rd, e, a;
    logic err;
    int waits;
    dready[1] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      a = 64'hD000 + 64'(i) * 64'h10;
      exp_q[3].push_back(a);
      apb_xfer(1, 32'h10, 1'b1, a, 8'hFF, rd, err, waits);
    end
    apb_xfer(1, 32'h10, 1'b1, 64'hDEAD, 8'hFF, rd, err, waits);
    total++;
    if (waits !== 0 || err !== 1'b1) begin
      bad++; $display("FAIL drop_fifth: got waits=%0d err=%b required waits=0 err=1", waits, err);
    end
    apb_xfer(1, 32'h18, 1'b0, 64'h0, 8'h00, rd, err, waits);
    total++;
    if (rd[15:8] !== 8'd4 || rd[1:0] !== 2'b10) begin
      bad++; $display("FAIL drop_status: got %h required count=4 full=1 empty=0", rd);
    end
    dready[1][1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (exp_q[3].size() == 0) begin
        bad++; $display("FAIL drop_drain%0d: got pop with empty scoreboard, required none", i);
      end else begin
        e = exp_q[3].pop_front();
        if (dvalid[1][1] !== 1'b1 || daddr[1][1] !== e) begin
          bad++; $display("FAIL drop_drain%0d: got valid=%b addr=%h required valid=1 addr=%h", i, dvalid[1][1], daddr[1][1], e);
        end
      end
    end
    @(posedge clk);
    #1 dready[1][1] = 1'b0;
    @(negedge clk);
    total++;
    if (dvalid[1][1] !== 1'b0) begin
      bad++; $display("FAIL drop_empty: got valid=%b required 0 (dropped write must not appear)", dvalid[1][1]);
    end
  endtask

  task automatic test_flush();
    logic [63:0] rd;
    logic err;
    int waits;
    int seen = 0;
    dready[0] = 2'b00;
    for (int i = 0; i < 2; i++) begin
      exp_q[0].push_back(64'hB000 + 64'(i) * 64'h100);
      apb_xfer(0, 32'h0, 1'b1, 64'hB000 + 64'(i) * 64'h100, 8'hFF, rd, err, waits);
    end
    fork
      apb_xfer(0, 32'h8, 1'b1, 64'h1, 8'hFF, rd, err, waits);
      begin
        @(posedge clk);
        @(posedge clk);
        #1 dready[0][0] = 1'b1;
        @(posedge clk);
        #1 dready[0][0] = 1'b0;
      end
    join
    exp_q[0].delete();
    total++;
    if (waits !== 0 || err !== 1'b0) begin
      bad++; $display("FAIL flush_resp: got waits=%0d err=%b required waits=0 err=0", waits, err);
    end
    @(negedge clk);
    total++;
    if (dvalid[0][0] !== 1'b0) begin
      bad++; $display("FAIL flush_valid: got %b required 0", dvalid[0][0]);
    end
    dready[0][0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (dvalid[0][0] === 1'b1) seen++;
    end
    dready[0][0] = 1'b0;
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL flush_no_pops: got %0d valid cycles required 0", seen);
    end
    apb_xfer(0, 32'h8, 1'b0, 64'h0, 8'h00, rd, err, waits);
    total++;
    if (rd[15:8] !== 8'd0 || rd[1:0] !== 2'b01) begin
      bad++; $display("FAIL flush_status: got %h required count=0 empty=1", rd);
    end
  endtask

  task automatic test_errors();
    logic [63:0] rd;
    logic err;
    int waits;
    logic [31:0] addrs [4] = '{32'h30, 32'h38, 32'h4, 32'h0};
    logic        wrs   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0]  strbs [4] = '{8'hFF, 8'h00, 8'h00, 8'h0F};
    for (int i = 0; i < 4; i++) begin
      apb_xfer(0, addrs[i], wrs[i], 64'h5555_0000 + 64'(i), strbs[i], rd, err, waits);
      total++;
      if (err !== 1'b1 || rd !== 64'h0) begin
        bad++; $display("FAIL err_access%0d: got err=%b data=%h required err=1 data=0", i, err, rd);
      end
    end
    @(negedge clk);
    total++;
    if (dvalid[0] !== 2'b00) begin
      bad++; $display("FAIL err_no_enqueue: got valid=%b required 00", dvalid[0]);
    end
    apb_xfer(0, 32'h0, 1'b0, 64'h0, 8'h00, rd, err, waits);
    total++;
    if (rd !== 64'hB100) begin
      bad++; $display("FAIL err_last_addr: got %h required b100", rd);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [63:0] rd;
    logic err;
    int waits;
    int bad_status = 0;
    dready[0] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      exp_q[1].push_back(64'hC000 + 64'(i));
      apb_xfer(0, 32'h10, 1'b1, 64'hC000 + 64'(i), 8'hFF, rd, err, waits);
    end
    @(posedge clk); #1;
    req[0].paddr = 32'h10; req[0].pwrite = 1'b1; req[0].pwdata = 64'hC400;
    req[0].pstrb = 8'hFF;  req[0].psel = 1'b1;   req[0].penable = 1'b0;
    @(posedge clk); #1;
    req[0].penable = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (rsp[0].pready !== 1'b0 || dvalid[0][1] !== 1'b1) begin
      bad++; $display("FAIL rstwait_pre: got pready=%b valid=%b required pready=0 valid=1", rsp[0].pready, dvalid[0][1]);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (rsp[0].pready !== 1'b0 || dvalid[0] !== 2'b00 || dvalid[1] !== 2'b00) begin
      bad++; $display("FAIL rstwait_async: got pready=%b valid0=%b valid1=%b required 0/00/00", rsp[0].pready, dvalid[0], dvalid[1]);
    end
    req[0] = '0;
    for (int q = 0; q < 4; q++) exp_q[q].delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < 2; c++) begin
        apb_xfer(s, 32'(c) * 32'h10 + 32'h8, 1'b0, 64'h0, 8'h00, rd, err, waits);
        if (rd[15:8] !== 8'd0 || rd[1:0] !== 2'b01) bad_status++;
      end
    end
    total++;
    if (bad_status !== 0) begin
      bad++; $display("FAIL rstwait_status: got %0d non-empty channels required 0", bad_status);
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_stall_on_full();
    test_drop_on_full();
    test_flush();
    test_errors();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
